// File: rtl/hilo_muldiv_unit_pkg.sv
// hilo_muldiv_unit_pkg: shared definitions for the HI/LO multiply/divide unit.
// This package holds the FSM state encodings, the default widths and the
// operation-select decode.
package hilo_muldiv_unit_pkg;

  // Default operand width. The divide runs one iteration per quotient bit.
  localparam int HILO_WIDTH    = 32;
  localparam int HILO_DIV_ITER = 32;

  // Unit states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL     = 2'd1,
    ST_DIV_RUN = 2'd2,
    ST_DIV_FIX = 2'd3
  } state_e;

  // Operation selected from the decoder's one-hot pairs.
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_MTHL = 2'd1,
    OP_MULT = 2'd2,
    OP_DIV  = 2'd3
  } op_e;

  // When several groups are set at once, divide wins over multiply, and
  // multiply wins over move-to. Move-from has no side effect and never
  // selects an operation.
  function automatic op_e decode_op(input logic [1:0] div_bits,
                                    input logic [1:0] mult_bits,
                                    input logic [1:0] mthl_bits);
    if (|div_bits)  return OP_DIV;
    if (|mult_bits) return OP_MULT;
    if (|mthl_bits) return OP_MTHL;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if: execute-stage bundle between the pipeline (master)
// and the HI/LO unit (slave). Signal names match the decoder outputs.
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [1:0]       MULT;
  logic [1:0]       DIV;
  logic [1:0]       MFHL;
  logic [1:0]       MTHL;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic [WIDTH-1:0] mf_data;
  logic             busy;
  logic             stall;

  modport master (
    output in_valid, MULT, DIV, MFHL, MTHL, src_a, src_b, flush,
    input  mf_data, busy, stall
  );

  modport slave (
    input  in_valid, MULT, DIV, MFHL, MTHL, src_a, src_b, flush,
    output mf_data, busy, stall
  );
endinterface

// File: rtl/hilo_muldiv_unit_div_step.sv
// div_step: one combinational restoring-division iteration.
// The remainder:quotient pair shifts left by one, the divisor is
// trial-subtracted from the widened remainder, and the new quotient bit is 1
// when that subtraction does not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quot,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quot
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;
  logic           w_fits;

  // Shift in the next dividend bit, then trial-subtract the divisor.
  always_comb begin
    w_shifted = {i_rem, i_quot[WIDTH-1]};
    w_trial   = w_shifted - {1'b0, i_divisor};
    w_fits    = ~w_trial[WIDTH];
    o_rem     = w_fits ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    o_quot    = {i_quot[WIDTH-2:0], w_fits};
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: execute-stage owner of the HI/LO registers.
// It performs mthi/mtlo, a 2-cycle signed/unsigned multiply, and a restoring
// divide of DIV_ITER iterations plus a sign-fix cycle.
// Optional macro HILO_DIV_ZERO_FAST_EN: a zero divisor skips the iteration
// phase and goes straight to the sign-fix cycle. The results are the same;
// only the latency changes.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH    = HILO_WIDTH,
  parameter int DIV_ITER = HILO_DIV_ITER  // must equal WIDTH
) (
  input  logic                clk,
  input  logic                resetn,
  hilo_muldiv_unit_if.slave   bus
);

  localparam int CNT_W = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;

  state_e r_state;
  state_e w_state_next;

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Multiply operands, extended by one bit so that a single signed multiply
  // covers both mult and multu.
  logic [WIDTH:0]   r_mul_a;
  logic [WIDTH:0]   r_mul_b;

  // Divide working state.
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_divisor;
  logic             r_q_neg;
  logic             r_r_neg;
  logic [CNT_W-1:0] r_cnt;

  logic             w_busy;
  logic             w_accept;
  op_e              w_op;
  logic             w_div_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_mul_signed;
  logic [2*WIDTH-1:0] w_mul_a_ext;
  logic [2*WIDTH-1:0] w_mul_b_ext;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quot_next;
  logic [WIDTH-1:0] w_quot_fixed;
  logic [WIDTH-1:0] w_rem_fixed;
`ifdef HILO_DIV_ZERO_FAST_EN
  logic             w_div_zero;
`endif

  assign w_busy   = (r_state != ST_IDLE);
  assign w_accept = bus.in_valid & ~w_busy & ~bus.flush;
  assign w_op     = decode_op(bus.DIV, bus.MULT, bus.MTHL);

  // Sign handling for div: divu (bit 1) treats both operands as unsigned.
  assign w_div_signed = ~bus.DIV[1];
  assign w_a_neg      = w_div_signed & bus.src_a[WIDTH-1];
  assign w_b_neg      = w_div_signed & bus.src_b[WIDTH-1];
  assign w_mag_a      = w_a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
  assign w_mag_b      = w_b_neg ? (~bus.src_b + 1'b1) : bus.src_b;
`ifdef HILO_DIV_ZERO_FAST_EN
  assign w_div_zero   = (w_mag_b == '0);
`endif

  // multu (bit 1) zero-extends the operands; mult sign-extends them.
  assign w_mul_signed = ~bus.MULT[1];

  // The low 2*WIDTH bits of the product of the sign-extended operands are
  // the exact product, for both the signed and the unsigned case.
  assign w_mul_a_ext = {{(WIDTH-1){r_mul_a[WIDTH]}}, r_mul_a};
  assign w_mul_b_ext = {{(WIDTH-1){r_mul_b[WIDTH]}}, r_mul_b};
  assign w_product   = w_mul_a_ext * w_mul_b_ext;

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .i_rem     (r_rem),
    .i_quot    (r_quot),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_quot    (w_quot_next)
  );

  // The quotient is negated when the operand signs differ; the remainder
  // follows the dividend's sign.
  assign w_quot_fixed = r_q_neg ? (~r_quot + 1'b1) : r_quot;
  assign w_rem_fixed  = r_r_neg ? (~r_rem + 1'b1) : r_rem;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: flush always returns to IDLE.
  always_comb begin
    w_state_next = r_state;
    if (bus.flush) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (w_op)
              OP_DIV: begin
`ifdef HILO_DIV_ZERO_FAST_EN
                w_state_next = w_div_zero ? ST_DIV_FIX : ST_DIV_RUN;
`else
                w_state_next = ST_DIV_RUN;
`endif
              end
              OP_MULT: w_state_next = ST_MUL;
              default: w_state_next = ST_IDLE;
            endcase
          end
        end
        ST_MUL:     w_state_next = ST_IDLE;
        ST_DIV_RUN: begin
          if (r_cnt == CNT_W'(DIV_ITER - 1)) begin
            w_state_next = ST_DIV_FIX;
          end
        end
        ST_DIV_FIX: w_state_next = ST_IDLE;
        default:    w_state_next = ST_IDLE;
      endcase
    end
  end

  // Datapath: operand capture, divide iterations and HI/LO writes.
  // A flush suppresses every HI/LO write from an in-flight operation.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (w_op)
              OP_DIV: begin
                r_divisor <= w_mag_b;
                r_q_neg   <= w_a_neg ^ w_b_neg;
                r_r_neg   <= w_a_neg;
                r_cnt     <= '0;
`ifdef HILO_DIV_ZERO_FAST_EN
                if (w_div_zero) begin
                  // This is the result the iterations would converge to:
                  // every trial subtract fits.
                  r_rem  <= w_mag_a;
                  r_quot <= '1;
                end else begin
                  r_rem  <= '0;
                  r_quot <= w_mag_a;
                end
`else
                r_rem     <= '0;
                r_quot    <= w_mag_a;
`endif
              end
              OP_MULT: begin
                r_mul_a <= {w_mul_signed & bus.src_a[WIDTH-1], bus.src_a};
                r_mul_b <= {w_mul_signed & bus.src_b[WIDTH-1], bus.src_b};
              end
              OP_MTHL: begin
                if (bus.MTHL[1]) r_hi <= bus.src_a;
                if (bus.MTHL[0]) r_lo <= bus.src_a;
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (!bus.flush) begin
            r_hi <= w_product[2*WIDTH-1:WIDTH];
            r_lo <= w_product[WIDTH-1:0];
          end
        end
        ST_DIV_RUN: begin
          if (!bus.flush) begin
            r_rem  <= w_rem_next;
            r_quot <= w_quot_next;
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        ST_DIV_FIX: begin
          if (!bus.flush) begin
            r_lo <= w_quot_fixed;
            r_hi <= w_rem_fixed;
          end
        end
        default: ;
      endcase
    end
  end

  // Read-back and pipeline handshake.
  assign bus.mf_data = bus.MFHL[1] ? r_hi : r_lo;
  assign bus.busy    = w_busy;
  assign bus.stall   = bus.in_valid & w_busy &
                       (|{bus.MULT, bus.DIV, bus.MFHL, bus.MTHL});

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed and randomized checks of hilo_muldiv_unit
// against an arithmetic reference model (honours HILO_DIV_ZERO_FAST_EN).
module tb_hilo_muldiv_unit;
  localparam int W = 32;
`ifdef HILO_DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int DIV_LAT = 33;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  hilo_muldiv_unit_if #(.WIDTH(W)) bus();

  hilo_muldiv_unit #(.WIDTH(W), .DIV_ITER(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit run_cmp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] div_ref(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return {a, (sgn && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF};
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  function automatic logic [63:0] mul_ref(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [63:0] u;
    if (sgn) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return 64'(p);
    end
    u = {32'd0, a} * {32'd0, b};
    return u;
  endfunction

  logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo;
  int m_cnt;

  // The model keeps HI/LO, the pending result and a count of the busy cycles
  // that remain.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_hi <= '0;
      m_lo <= '0;
      m_pend_hi <= '0;
      m_pend_lo <= '0;
      m_cnt <= 0;
    end else if (m_cnt > 0) begin
      if (bus.flush) m_cnt <= 0;
      else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_hi <= m_pend_hi;
          m_lo <= m_pend_lo;
        end
      end
    end else if (bus.in_valid && !bus.flush) begin
      if (|bus.DIV) begin
        {m_pend_hi, m_pend_lo} <= div_ref(!bus.DIV[1], bus.src_a, bus.src_b);
        m_cnt <= (FAST && bus.src_b == 32'd0) ? 1 : DIV_LAT;
        $display("[%0t] accept %s a=%h b=%h", $time, bus.DIV[1] ? "divu" : "div", bus.src_a, bus.src_b);
      end else if (|bus.MULT) begin
        {m_pend_hi, m_pend_lo} <= mul_ref(!bus.MULT[1], bus.src_a, bus.src_b);
        m_cnt <= 1;
        $display("[%0t] accept %s a=%h b=%h", $time, bus.MULT[1] ? "multu" : "mult", bus.src_a, bus.src_b);
      end else if (|bus.MTHL) begin
        if (bus.MTHL[1]) m_hi <= bus.src_a;
        if (bus.MTHL[0]) m_lo <= bus.src_a;
        $display("[%0t] accept mthl=%b a=%h", $time, bus.MTHL, bus.src_a);
      end
    end
  end

  // Every-cycle comparison of the DUT outputs against the model.
  always @(negedge clk) begin
    if (run_cmp) begin
      check("busy", {63'd0, bus.busy}, {63'd0, m_cnt != 0});
      check("stall", {63'd0, bus.stall},
            {63'd0, bus.in_valid && (m_cnt != 0) && (|{bus.MULT, bus.DIV, bus.MFHL, bus.MTHL})});
      check("mf_data", {32'd0, bus.mf_data}, {32'd0, bus.MFHL[1] ? m_hi : m_lo});
    end
  end

  // ---------------- driver helpers ----------------
  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.MULT = 2'b00;
    bus.DIV = 2'b00;
    bus.MFHL = 2'b00;
    bus.MTHL = 2'b00;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] mult, input logic [1:0] div, input logic [1:0] mthl,
                       input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.MULT = mult;
    bus.DIV = div;
    bus.MTHL = mthl;
    bus.src_a = a;
    bus.src_b = b;
    step();
    idle_inputs();
  endtask

  task automatic read_hl(input bit hi, input string name, input logic [31:0] exp);
    bus.in_valid = 1'b1;
    bus.MFHL = hi ? 2'b10 : 2'b01;
    @(negedge clk);
    check(name, {32'd0, bus.mf_data}, {32'd0, exp});
    check({name, "_nostall"}, {63'd0, bus.stall}, 64'd0);
    step();
    idle_inputs();
  endtask

  // Count the busy cycles that follow an accepted operation; a bound that
  // expires counts as a failed comparison.
  task automatic busy_cycles(input string name, input int exp);
    int n;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
      step();
    end
    check(name, 64'(n), 64'(exp));
    step();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int kind;
    idle_inputs();
    #1 resetn = 1'b0;
    run_cmp = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_mf", {32'd0, bus.mf_data}, 64'd0);
    resetn = 1'b1;
    step();

    // mult -2 * 3
    issue(2'b01, 2'b00, 2'b00, 32'hFFFF_FFFE, 32'd3);
    busy_cycles("mult_busy", 1);
    read_hl(1'b1, "mult_hi", 32'hFFFF_FFFF);
    read_hl(1'b0, "mult_lo", 32'hFFFF_FFFA);

    // multu max * max
    issue(2'b10, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    busy_cycles("multu_busy", 1);
    read_hl(1'b1, "multu_hi", 32'hFFFF_FFFE);
    read_hl(1'b0, "multu_lo", 32'h0000_0001);
    check("model_multu_lo", {32'd0, m_lo}, 64'h1);

    // div -7 / 2 with an mflo presented at T+5
    issue(2'b00, 2'b01, 2'b00, 32'hFFFF_FFF9, 32'd2);
    repeat (4) step();
    bus.in_valid = 1'b1;
    bus.MFHL = 2'b01;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!bus.stall) break;
      n++;
      step();
    end
    check("div_mflo_stall_cycles", 64'(n), 64'd29);
    check("div_lo", {32'd0, bus.mf_data}, {32'd0, 32'hFFFF_FFFD});
    step();
    idle_inputs();
    read_hl(1'b1, "div_hi", 32'hFFFF_FFFF);
    check("model_div_lo", {32'd0, m_lo}, {32'd0, 32'hFFFF_FFFD});

    // divu 100 / 0
    issue(2'b00, 2'b10, 2'b00, 32'd100, 32'd0);
    busy_cycles("divu0_busy", FAST ? 1 : DIV_LAT);
    read_hl(1'b0, "divu0_lo", 32'hFFFF_FFFF);
    read_hl(1'b1, "divu0_hi", 32'd100);

    // div -5 / 0
    issue(2'b00, 2'b01, 2'b00, 32'hFFFF_FFFB, 32'd0);
    busy_cycles("div0_busy", FAST ? 1 : DIV_LAT);
    read_hl(1'b0, "div0_lo", 32'h0000_0001);
    read_hl(1'b1, "div0_hi", 32'hFFFF_FFFB);

    // signed overflow
    issue(2'b00, 2'b01, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    busy_cycles("divovf_busy", DIV_LAT);
    read_hl(1'b0, "divovf_lo", 32'h8000_0000);
    read_hl(1'b1, "divovf_hi", 32'h0);

    // mthi, then a divu flushed at T+10
    issue(2'b00, 2'b00, 2'b01, 32'hCAFE_F00D, 32'd0);
    issue(2'b00, 2'b00, 2'b10, 32'h1234_5678, 32'd0);
    issue(2'b00, 2'b10, 2'b00, 32'd10, 32'd3);
    repeat (9) step();
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_busy_T10", {63'd0, bus.busy}, 64'd1);
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy_T11", {63'd0, bus.busy}, 64'd0);
    step();
    read_hl(1'b1, "flush_hi", 32'h1234_5678);
    read_hl(1'b0, "flush_lo", 32'hCAFE_F00D);

    // an operation that arrives together with flush is discarded
    bus.flush = 1'b1;
    issue(2'b00, 2'b00, 2'b10, 32'h0000_DEAD, 32'd0);
    read_hl(1'b1, "flush_discard_hi", 32'h1234_5678);

    // reset in the middle of DIV_RUN
    issue(2'b00, 2'b01, 2'b00, 32'd1000, 32'd7);
    repeat (5) step();
    #2 resetn = 1'b0;
    #1;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_lo", {32'd0, bus.mf_data}, 64'd0);
    bus.MFHL = 2'b10;
    #1;
    check("rst_hi", {32'd0, bus.mf_data}, 64'd0);
    bus.MFHL = 2'b00;
    step();
    resetn = 1'b1;
    step();
    issue(2'b00, 2'b00, 2'b01, 32'd5, 32'd0);
    read_hl(1'b0, "rst_mtlo_lo", 32'd5);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      idle_inputs();
      bus.in_valid = ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1: bus.DIV = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
        2, 3: bus.MULT = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
        4, 5: bus.MTHL = 2'($urandom_range(1, 3));
        6, 7, 8: bus.MFHL = 2'($urandom_range(1, 2));
        default: begin
          bus.DIV = 2'($urandom_range(0, 3));
          bus.MULT = 2'($urandom_range(0, 3));
          bus.MFHL = 2'($urandom_range(0, 3));
          bus.MTHL = 2'($urandom_range(0, 3));
        end
      endcase
      bus.src_a = pick();
      bus.src_b = pick();
      bus.flush = ($urandom_range(0, 59) == 0);
      step();
    end
    idle_inputs();
    repeat (40) step();

    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
